// File: rtl/noise_dither_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noise_dither_mixer_pkg
// Purpose  : Shared definitions for the noise/dither mixer and the saturating
//            clamp that later gain stages also reuse.
//            - mode_e      : per-sample processing mode carried down the pipe
//            - SAT_CNT_W   : width of the saturation event counter
//            - clamp_max / clamp_min : signed range limits of a W-bit word
// Revision : 1.0 - initial release
// ============================================================================
package noise_dither_mixer_pkg;

    // Processing mode, captured with each sample on accept.
    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,    // output = sample
        MODE_DITHER = 2'b01,    // output = sample + scaled noise
        MODE_NOISE  = 2'b10,    // output = scaled noise
        MODE_MUTE   = 2'b11     // output = 0
    } mode_e;

    // Saturation event counter width.
    localparam int SAT_CNT_W = 16;

    // Largest value representable in a signed w-bit word (w <= 31).
    function automatic int clamp_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed w-bit word (w <= 31).
    function automatic int clamp_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage : noise_dither_mixer_pkg
`default_nettype wire

// File: rtl/noise_dither_mixer_sat_clamp.sv
`default_nettype none
// ============================================================================
// Module   : sat_clamp
// Purpose  : Purely combinational signed saturation from W+1 bits down to W
//            bits. Values outside [-2^(W-1), 2^(W-1)-1] are pinned to the
//            nearest limit and flagged.
// Ports    : din_i  in  W+1  signed value to be narrowed
//            dout_o out  W    clamped signed value
//            ovf_o  out  1    high when clamping altered the value
// Revision : 1.0 - initial release
// ============================================================================
module sat_clamp
    import noise_dither_mixer_pkg::*;
#(
    parameter int W = 12
) (
    input  logic signed [W:0]   din_i,
    output logic signed [W-1:0] dout_o,
    output logic                ovf_o
);

    localparam int LIM_MAX = clamp_max(W);
    localparam int LIM_MIN = clamp_min(W);

    always_comb begin
        // A W+1-bit value fits in W bits exactly when its top two bits agree;
        // the top bit then tells which rail was crossed.
        ovf_o  = din_i[W] ^ din_i[W-1];
        dout_o = din_i[W-1:0];
        if (ovf_o) begin
            if (din_i[W]) begin
                dout_o = LIM_MIN[W-1:0];
            end else begin
                dout_o = LIM_MAX[W-1:0];
            end
        end
    end

endmodule : sat_clamp
`default_nettype wire

// File: rtl/noise_dither_mixer.sv
`default_nettype none
// ============================================================================
// Module   : noise_dither_mixer
// Purpose  : Adds scaled, centred LFSR noise to signed PCM samples, with
//            bypass / noise-only / mute modes. Two-stage valid/ready pipeline,
//            saturating output and a saturating clamp-event counter.
// Ports    : clk          in   1        system clock
//            reset        in   1        synchronous active-high reset
//            noise_in     in   NOISE_W  LFSR word, offset binary
//            mode         in   2        00 bypass 01 dither 10 noise 11 mute
//            noise_shift  in   3        arithmetic right shift of the noise
//            s_valid      in   1        input sample valid
//            s_ready      out  1        input sample can be accepted
//            s_data       in   DATA_W   signed input sample
//            m_valid      out  1        output sample valid
//            m_ready      in   1        downstream accepts output
//            m_data       out  DATA_W   signed output sample
//            m_sat        out  1        m_data was clamped
//            sat_clr      in   1        clear the clamp counter
//            sat_count    out  16       clamped samples seen, sticks at max
// Notes    : NOISE_W must lie in 4..DATA_W so the centred noise always fits
//            the DATA_W+1-bit working width without overflow.
// Revision : 1.0 - initial release
// ============================================================================
module noise_dither_mixer
    import noise_dither_mixer_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int NOISE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NOISE_W-1:0]   noise_in,
    input  logic [1:0]           mode,
    input  logic [2:0]           noise_shift,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_sat,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_count
);

    // ------------------------------------------------------------------
    // Stage 1: captured sample plus the controls that travel with it
    // ------------------------------------------------------------------
    logic                      s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0]  s1_data_q,  s1_data_d;
    mode_e                     s1_mode_q,  s1_mode_d;
    logic [2:0]                s1_shift_q, s1_shift_d;
    logic signed [NOISE_W-1:0] s1_noise_q, s1_noise_d;

    // ------------------------------------------------------------------
    // Stage 2: output register and clamp counter
    // ------------------------------------------------------------------
    logic                      m_valid_q, m_valid_d;
    logic [DATA_W-1:0]         m_data_q,  m_data_d;
    logic                      m_sat_q,   m_sat_d;
    logic [SAT_CNT_W-1:0]      sat_cnt_q, sat_cnt_d;

    // Handshake
    logic s2_free;      // stage 2 empty or being drained this cycle
    logic s1_adv;       // stage 1 moves into stage 2 this cycle
    logic accept;       // new sample captured into stage 1
    logic sat_load;     // a clamped sample lands in stage 2 this cycle

    // Datapath, all at DATA_W+1 bits so the dither sum cannot wrap
    logic signed [DATA_W:0]    sample_ext;
    logic signed [DATA_W:0]    noise_ext;
    logic signed [DATA_W:0]    noise_scaled;
    logic signed [DATA_W:0]    mix_val;
    logic signed [DATA_W-1:0]  clamp_val;
    logic                      clamp_ovf;

    assign s2_free  = !m_valid_q || m_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    // Independent of s_valid; may follow m_ready through s2_free.
    assign s_ready  = !s1_valid_q || s2_free;
    assign accept   = s_valid && s_ready;
    assign sat_load = s1_adv && clamp_ovf;

    // Sign-extend both operands; the shift is applied after extension so the
    // arithmetic shift keeps the noise sign for every shift amount.
    assign sample_ext   = {s1_data_q[DATA_W-1], s1_data_q};
    assign noise_ext    = {{(DATA_W+1-NOISE_W){s1_noise_q[NOISE_W-1]}}, s1_noise_q};
    assign noise_scaled = noise_ext >>> s1_shift_q;

    always_comb begin
        mix_val = '0;
        unique case (s1_mode_q)
            MODE_BYPASS: mix_val = sample_ext;
            MODE_DITHER: mix_val = sample_ext + noise_scaled;
            MODE_NOISE:  mix_val = noise_scaled;
            MODE_MUTE:   mix_val = '0;
            default:     mix_val = '0;
        endcase
    end

    sat_clamp #(
        .W      (DATA_W)
    ) u_sat_clamp (
        .din_i  (mix_val),
        .dout_o (clamp_val),
        .ovf_o  (clamp_ovf)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_shift_d = s1_shift_q;
        s1_noise_d = s1_noise_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_sat_d    = m_sat_q;
        sat_cnt_d  = sat_cnt_q;

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = s_data;
            s1_mode_d  = mode_e'(mode);
            s1_shift_d = noise_shift;
            // Inverting the MSB turns offset binary into two's complement,
            // centring the free-running LFSR word around zero.
            s1_noise_d = {~noise_in[NOISE_W-1], noise_in[NOISE_W-2:0]};
        end

        if (s1_adv) begin
            m_valid_d = 1'b1;
            m_data_d  = clamp_val;
            m_sat_d   = clamp_ovf;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        // A clear coinciding with a clamp leaves that clamp counted.
        if (sat_clr) begin
            sat_cnt_d = sat_load ? SAT_CNT_W'(1) : '0;
        end else if (sat_load && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_BYPASS;
            s1_shift_q <= '0;
            s1_noise_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_sat_q    <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_shift_q <= s1_shift_d;
            s1_noise_q <= s1_noise_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_sat_q    <= m_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sat     = m_sat_q;
    assign sat_count = sat_cnt_q;

endmodule : noise_dither_mixer
`default_nettype wire
